ws2812_rx: RTL and testbench

Single-wire WS2812 (NeoPixel) receiver/decoder: samples the serial LED data line that our matrix driver transmits on `_48b`, measures each high pulse, and reassembles 24-bit GRB pixels plus frame-latch events. It sits beside the top-level driver in simulation and on-board loopback, giving the bench a self-checking view of what the LED chain would receive. All timing is in cycles of the 12 MHz system clock (83.3 ns).

---
 rtl/ws2812_rx.sv | 251 +++++++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver. Synchronizes the data line, measures
// each high pulse in system clock cycles, assembles 24-bit GRB pixels
// (first bit in [23]) and reports frame latches and protocol errors.
module ws2812_rx #(
    parameter int THRESH       = 6,    // widths 1..THRESH decode as 0
    parameter int MAX_HIGH     = 12,   // widths above this are an error
    parameter int RESET_CYCLES = 600   // low time that latches a frame
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic [8:0]  frame_pixels,
    output logic        err
);

    // Counter widths: low counter saturates at RESET_CYCLES, high counter
    // saturates one past MAX_HIGH so an overlong pulse stays distinguishable.
    localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
    localparam int HIGH_W = $clog2(MAX_HIGH + 2);

    localparam logic [LOW_W-1:0]  LOW_SAT   = LOW_W'(RESET_CYCLES);
    localparam logic [LOW_W-1:0]  LOW_ONE   = LOW_W'(1);
    localparam logic [HIGH_W-1:0] HIGH_SAT  = HIGH_W'(MAX_HIGH + 1);
    localparam logic [HIGH_W-1:0] HIGH_THR  = HIGH_W'(THRESH);
    localparam logic [HIGH_W-1:0] HIGH_MAX  = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_ONE  = HIGH_W'(1);
    localparam logic [4:0]        BIT_LAST  = 5'd23;
    localparam logic [8:0]        PIX_SAT   = 9'd511;

    // DISARMED: ignore the line until it has been seen low once, so a pulse
    // already in flight at reset is never measured from its middle.
    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_LOW      = 2'd1,
        ST_HIGH     = 2'd2
    } state_t;

    // Synchronizer and its fill tracker
    logic        r_s1;
    logic        r_s2;
    logic        r_s2_q;
    logic [1:0]  r_fill;

    // Decoder state
    state_t             r_state;
    logic [LOW_W-1:0]   r_low_cnt;
    logic [HIGH_W-1:0]  r_high_cnt;
    logic [22:0]        r_shift;
    logic [4:0]         r_bit_cnt;
    logic [8:0]         r_pix_cnt;
    logic               r_seen;

    // Registered outputs
    logic [23:0] r_pixel_data;
    logic        r_pixel_valid;
    logic [7:0]  r_pixel_index;
    logic        r_frame_done;
    logic [8:0]  r_frame_pixels;
    logic        r_err;

    // Next-state values
    state_t             w_state_nxt;
    logic [LOW_W-1:0]   w_low_cnt_nxt;
    logic [HIGH_W-1:0]  w_high_cnt_nxt;
    logic [22:0]        w_shift_nxt;
    logic [4:0]         w_bit_cnt_nxt;
    logic [8:0]         w_pix_cnt_nxt;
    logic               w_seen_nxt;
    logic [23:0]        w_pixel_data_nxt;
    logic               w_pixel_valid_nxt;
    logic [7:0]         w_pixel_index_nxt;
    logic               w_frame_done_nxt;
    logic [8:0]         w_frame_pixels_nxt;
    logic               w_err_nxt;

    // Decode helpers
    logic w_armed;
    logic w_rise;
    logic w_fall;
    logic w_is_one;
    logic w_too_long;

    // The synchronizer holds reset values for two edges after release; only
    // after that does r_s2 reflect the real line.
    assign w_armed    = (r_fill == 2'd2);
    assign w_rise     = r_s2 & ~r_s2_q;
    assign w_fall     = ~r_s2 & r_s2_q;
    assign w_is_one   = (r_high_cnt > HIGH_THR);
    assign w_too_long = (r_high_cnt > HIGH_MAX);

    // Two-flop synchronizer for the asynchronous line plus a delayed copy for edge detection.
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_q <= 1'b0;
            r_fill <= 2'd0;
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_s2_q <= r_s2;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    // Next-state, pulse measurement, bit assembly and frame latch decisions.
    // NOTE: every variable gets its hold/default value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt        = r_state;
        w_low_cnt_nxt      = r_low_cnt;
        w_high_cnt_nxt     = r_high_cnt;
        w_shift_nxt        = r_shift;
        w_bit_cnt_nxt      = r_bit_cnt;
        w_pix_cnt_nxt      = r_pix_cnt;
        w_seen_nxt         = r_seen;
        w_pixel_data_nxt   = r_pixel_data;
        w_pixel_valid_nxt  = 1'b0;
        w_pixel_index_nxt  = r_pixel_index;
        w_frame_done_nxt   = 1'b0;
        w_frame_pixels_nxt = r_frame_pixels;
        w_err_nxt          = 1'b0;

        case (r_state)
            ST_DISARMED: begin
                if (w_armed && !r_s2) begin
                    w_state_nxt   = ST_LOW;
                    w_low_cnt_nxt = LOW_ONE;
                end
            end

            ST_LOW: begin
                if (w_rise) begin
                    w_state_nxt    = ST_HIGH;
                    w_high_cnt_nxt = HIGH_ONE;
                    w_low_cnt_nxt  = '0;
                end else if (r_low_cnt != LOW_SAT) begin
                    w_low_cnt_nxt = r_low_cnt + LOW_ONE;
                    // Latch fires only on the count reaching the limit, so a
                    // long low produces a single event; idle lows produce none.
                    if (w_low_cnt_nxt == LOW_SAT && r_seen) begin
                        w_frame_done_nxt   = 1'b1;
                        w_frame_pixels_nxt = r_pix_cnt;
                        w_pix_cnt_nxt      = '0;
                        w_seen_nxt         = 1'b0;
                        w_bit_cnt_nxt      = '0;
                        // A partial pixel at latch time is dropped and flagged.
                        if (r_bit_cnt != 5'd0) begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
            end

            ST_HIGH: begin
                if (w_fall) begin
                    w_state_nxt   = ST_LOW;
                    w_low_cnt_nxt = LOW_ONE;
                    if (w_too_long) begin
                        // Overlong pulse: discard the partial pixel, shift nothing.
                        w_err_nxt     = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_seen_nxt = 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_pixel_data_nxt  = {r_shift, w_is_one};
                            w_pixel_valid_nxt = 1'b1;
                            w_pixel_index_nxt = r_pix_cnt[7:0];
                            w_bit_cnt_nxt     = '0;
                            if (r_pix_cnt != PIX_SAT) begin
                                w_pix_cnt_nxt = r_pix_cnt + 9'd1;
                            end
                        end else begin
                            w_shift_nxt   = {r_shift[21:0], w_is_one};
                            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        end
                    end
                end else if (r_high_cnt != HIGH_SAT) begin
                    w_high_cnt_nxt = r_high_cnt + HIGH_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_DISARMED;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_DISARMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Width counters, shift register and pixel bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_low_cnt  <= '0;
            r_high_cnt <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_seen     <= 1'b0;
        end else begin
            r_low_cnt  <= w_low_cnt_nxt;
            r_high_cnt <= w_high_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_pix_cnt  <= w_pix_cnt_nxt;
            r_seen     <= w_seen_nxt;
        end
    end

    // Output registers: pulses last one cycle, held values change only with their pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel_data   <= '0;
            r_pixel_valid  <= 1'b0;
            r_pixel_index  <= '0;
            r_frame_done   <= 1'b0;
            r_frame_pixels <= '0;
            r_err          <= 1'b0;
        end else begin
            r_pixel_data   <= w_pixel_data_nxt;
            r_pixel_valid  <= w_pixel_valid_nxt;
            r_pixel_index  <= w_pixel_index_nxt;
            r_frame_done   <= w_frame_done_nxt;
            r_frame_pixels <= w_frame_pixels_nxt;
            r_err          <= w_err_nxt;
        end
    end

    assign pixel_data   = r_pixel_data;
    assign pixel_valid  = r_pixel_valid;
    assign pixel_index  = r_pixel_index;
    assign frame_done   = r_frame_done;
    assign frame_pixels = r_frame_pixels;
    assign err          = r_err;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: drives WS2812 pulse trains into ws2812_rx, records every output
// event with its clock-edge number, and compares against a pulse-level model
// that derives bits, pixels, latches and errors from pulse widths.
module tb_ws2812_rx;

    localparam int THRESH   = 6;
    localparam int MAX_HIGH = 12;
    localparam int RC       = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic [8:0]  frame_pixels;
    logic        err;

    ws2812_rx #(
        .THRESH       (THRESH),
        .MAX_HIGH     (MAX_HIGH),
        .RESET_CYCLES (RC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Edge counter and the reset level seen at each rising edge
    int   cyc = 0;
    logic rst_at_edge = 1'b1;
    always @(posedge clk) begin
        cyc++;
        rst_at_edge = reset;
    end

    typedef struct {
        logic [23:0] data;
        int          idx;
        int          cyc;
    } px_ev_t;

    typedef struct {
        int pix;
        int cyc;
    } fr_ev_t;

    px_ev_t act_px[$];
    px_ev_t exp_px[$];
    fr_ev_t act_fr[$];
    fr_ev_t exp_fr[$];
    int     act_err[$];
    int     exp_err[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_stray  = 0;

    logic [23:0] prev_data;
    logic [7:0]  prev_idx;
    logic [8:0]  prev_fpix;

    // Event recorder; also counts held outputs changing without their pulse
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            if (pixel_valid) begin
                act_px.push_back('{pixel_data, int'(pixel_index), cyc});
            end else if (pixel_data !== prev_data || pixel_index !== prev_idx) begin
                n_stray++;
            end
            if (frame_done) begin
                act_fr.push_back('{int'(frame_pixels), cyc});
            end else if (frame_pixels !== prev_fpix) begin
                n_stray++;
            end
            if (err) begin
                act_err.push_back(cyc);
            end
        end
        prev_data = pixel_data;
        prev_idx  = pixel_index;
        prev_fpix = frame_pixels;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse-level model
    int          m_bits;
    int          m_count;
    logic [23:0] m_acc;
    bit          m_seen;

    task automatic model_reset();
        m_bits  = 0;
        m_count = 0;
        m_acc   = '0;
        m_seen  = 1'b0;
    endtask

    // hi = high width, lo = following low width, k = edge of first low sample
    task automatic model_pulse(input int hi, input int lo, input int k);
        if (hi > MAX_HIGH) begin
            exp_err.push_back(k + 2);
            m_bits = 0;
            m_acc  = '0;
        end else begin
            m_acc  = {m_acc[22:0], (hi > THRESH)};
            m_bits++;
            m_seen = 1'b1;
            if (m_bits == 24) begin
                exp_px.push_back('{m_acc, m_count % 256, k + 2});
                m_count = (m_count < 511) ? m_count + 1 : 511;
                m_bits  = 0;
                m_acc   = '0;
            end
        end
        if (lo >= RC && m_seen) begin
            exp_fr.push_back('{m_count, k + RC + 1});
            if (m_bits != 0) begin
                exp_err.push_back(k + RC + 1);
            end
            m_count = 0;
            m_bits  = 0;
            m_acc   = '0;
            m_seen  = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at a falling edge
    task automatic drive_pulse(input int hi, input int lo);
        int k;
        din = 1'b1;
        repeat (hi) @(negedge clk);
        k   = cyc + 1;
        din = 1'b0;
        model_pulse(hi, lo, k);
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] val, input int nbits,
                             input int hi0, input int lo0, input int hi1, input int lo1,
                             input int last_lo);
        logic b;
        for (int i = nbits - 1; i >= 0; i--) begin
            b = val[i];
            drive_pulse(b ? hi1 : hi0, (i == 0) ? last_lo : (b ? lo1 : lo0));
        end
    endtask

    function automatic logic [23:0] px_data(input int i);
        return (i < act_px.size()) ? act_px[i].data : 24'h0;
    endfunction

    function automatic int px_idx(input int i);
        return (i < act_px.size()) ? act_px[i].idx : -1;
    endfunction

    function automatic int fr_pix(input int i);
        return (i < act_fr.size()) ? act_fr[i].pix : -1;
    endfunction

    function automatic int fr_cyc(input int i);
        return (i < act_fr.size()) ? act_fr[i].cyc : -1;
    endfunction

    function automatic int err_cyc(input int i);
        return (i < act_err.size()) ? act_err[i] : -2;
    endfunction

    task automatic clear_events();
        act_px.delete();
        exp_px.delete();
        act_fr.delete();
        exp_fr.delete();
        act_err.delete();
        exp_err.delete();
    endtask

    // Compare recorded events with the model, including their edge numbers
    task automatic compare_run(input string tag);
        check($sformatf("%s.npx", tag), act_px.size(), exp_px.size());
        for (int i = 0; i < act_px.size() && i < exp_px.size(); i++) begin
            check($sformatf("%s.px%0d.data", tag, i), act_px[i].data, exp_px[i].data);
            check($sformatf("%s.px%0d.idx", tag, i), act_px[i].idx, exp_px[i].idx);
            check($sformatf("%s.px%0d.cyc", tag, i), act_px[i].cyc, exp_px[i].cyc);
        end
        check($sformatf("%s.nfr", tag), act_fr.size(), exp_fr.size());
        for (int i = 0; i < act_fr.size() && i < exp_fr.size(); i++) begin
            check($sformatf("%s.fr%0d.pix", tag, i), act_fr[i].pix, exp_fr[i].pix);
            check($sformatf("%s.fr%0d.cyc", tag, i), act_fr[i].cyc, exp_fr[i].cyc);
        end
        check($sformatf("%s.nerr", tag), act_err.size(), exp_err.size());
        for (int i = 0; i < act_err.size() && i < exp_err.size(); i++) begin
            check($sformatf("%s.err%0d.cyc", tag, i), act_err[i], exp_err[i]);
        end
        clear_events();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".pixel_data"}, pixel_data, 0);
        check({tag, ".pixel_valid"}, pixel_valid, 0);
        check({tag, ".pixel_index"}, pixel_index, 0);
        check({tag, ".frame_done"}, frame_done, 0);
        check({tag, ".frame_pixels"}, frame_pixels, 0);
        check({tag, ".err"}, err, 0);
    endtask

    // Width table: one leading pulse of width hi, then 23 ones, then a latch
    typedef struct {
        int          hi;
        int          exp_npx;
        logic [23:0] exp_data;
        int          exp_fpix;
        int          exp_nerr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   hi;
        int   lo;
        logic b;
        int   gaps[4];
        logic [23:0] wb_val;

        vecs[0] = '{1,  1, 24'h7FFFFF, 1, 0};
        vecs[1] = '{6,  1, 24'h7FFFFF, 1, 0};
        vecs[2] = '{7,  1, 24'hFFFFFF, 1, 0};
        vecs[3] = '{12, 1, 24'hFFFFFF, 1, 0};
        vecs[4] = '{13, 0, 24'h000000, 0, 2};
        vecs[5] = '{20, 0, 24'h000000, 0, 2};
        gaps    = '{599, 600, 601, 700};

        reset = 1'b1;
        din   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_outputs_zero("idle");
        check("idle.events", act_px.size() + act_fr.size() + act_err.size(), 0);

        // Single pixel 0x00FF00 with nominal WS2812 timing
        send_bits(24'h00FF00, 24, 4, 11, 9, 6, 700);
        check("t1.npx", act_px.size(), 1);
        check("t1.data", px_data(0), 24'h00FF00);
        check("t1.idx", px_idx(0), 0);
        check("t1.fpix", fr_pix(0), 1);
        check("t1.frame_pixels_held", frame_pixels, 1);
        check("t1.nerr", act_err.size(), 0);
        compare_run("t1");

        // Three pixels back-to-back, latch, then a second idle low stretch
        send_bits(24'h123456, 24, 3, 6, 9, 6, 6);
        send_bits(24'hABCDEF, 24, 3, 6, 9, 6, 6);
        send_bits(24'h000001, 24, 3, 6, 9, 6, 700);
        check("t2.data0", px_data(0), 24'h123456);
        check("t2.data1", px_data(1), 24'hABCDEF);
        check("t2.data2", px_data(2), 24'h000001);
        check("t2.idx2", px_idx(2), 2);
        check("t2.fpix", fr_pix(0), 3);
        compare_run("t2");
        repeat (700) @(negedge clk);
        check("t2.no_extra_frame", act_fr.size(), 0);
        check("t2.frame_pixels_held", frame_pixels, 3);
        clear_events();

        // Width classification table
        for (int v = 0; v < 6; v++) begin
            drive_pulse(vecs[v].hi, 6);
            send_bits(24'h7FFFFF, 23, 3, 6, 9, 6, 700);
            check($sformatf("tbl%0d.npx", v), act_px.size(), vecs[v].exp_npx);
            check($sformatf("tbl%0d.data", v), px_data(0), vecs[v].exp_data);
            check($sformatf("tbl%0d.nfr", v), act_fr.size(), 1);
            check($sformatf("tbl%0d.fpix", v), fr_pix(0), vecs[v].exp_fpix);
            check($sformatf("tbl%0d.nerr", v), act_err.size(), vecs[v].exp_nerr);
            compare_run($sformatf("tbl%0d", v));
        end

        // Overlong pulse mid-pixel, then a clean pixel using boundary widths
        repeat (5) drive_pulse(9, 6);
        drive_pulse(13, 6);
        wb_val = 24'hC3A5F0;
        for (int i = 23; i >= 0; i--) begin
            b  = wb_val[i];
            hi = b ? ((i % 2) ? 7 : 12) : ((i % 2) ? 6 : 1);
            drive_pulse(hi, (i == 0) ? 700 : 1 + (i % 3));
        end
        check("wb.nerr", act_err.size(), 1);
        check("wb.data", px_data(0), 24'hC3A5F0);
        check("wb.idx", px_idx(0), 0);
        check("wb.fpix", fr_pix(0), 1);
        compare_run("wb");

        // Ten bits then latch: frame_done and err together, no pixel
        send_bits(24'h2B5, 10, 2, 3, 8, 2, 700);
        check("part.npx", act_px.size(), 0);
        check("part.fpix", fr_pix(0), 0);
        check("part.err_with_frame", err_cyc(0), fr_cyc(0));
        compare_run("part");

        // 599-cycle low inside a pixel does not latch
        send_bits(24'h9C3, 12, 3, 6, 9, 6, 599);
        check("gap.no_frame", act_fr.size(), 0);
        send_bits(24'hE71, 12, 3, 6, 9, 6, 700);
        check("gap.data", px_data(0), 24'h9C3E71);
        check("gap.nfr", act_fr.size(), 1);
        compare_run("gap");

        // Randomized pulse trains, including gaps around the latch threshold
        for (int p = 0; p < 30; p++) begin
            for (int bi = 0; bi < 24; bi++) begin
                hi = ($urandom_range(0, 39) == 0) ? int'($urandom_range(13, 20))
                                                  : int'($urandom_range(1, 12));
                lo = int'($urandom_range(1, 8));
                if ((bi == 23 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                    lo = gaps[$urandom_range(0, 3)];
                end
                if (p == 29 && bi == 23) begin
                    lo = 700;
                end
                drive_pulse(hi, lo);
            end
        end
        compare_run("rand");

        // Reset while the line is high; that pulse must never decode
        send_bits(24'hFFF, 12, 3, 6, 9, 6, 6);
        din = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_events();
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs_zero("mrst.in_reset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_outputs_zero("mrst.after");
        check("mrst.events", act_px.size() + act_fr.size() + act_err.size(), 0);
        din = 1'b0;
        repeat (20) @(negedge clk);
        check("mrst.high_ignored", act_px.size() + act_fr.size() + act_err.size(), 0);
        send_bits(24'h5A5A5A, 24, 3, 6, 9, 6, 700);
        check("mrst.data", px_data(0), 24'h5A5A5A);
        check("mrst.idx", px_idx(0), 0);
        check("mrst.fpix", fr_pix(0), 1);
        compare_run("mrst");

        check("held_outputs_stray", n_stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
